// File: rtl/conv_weight_loader_if.sv
// Weight-beat stream between a producer and conv_weight_loader (valid/ready, signed 8-bit beats).
interface conv_weight_loader_if;
  logic              s_valid;
  logic signed [7:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/conv_weight_loader.sv
// Run-time loadable 8x(3x3) weight store: streams filter-major weights into a 72-entry memory
// and serves a registered 1-cycle read port. Optional trailing checksum: CONV_WEIGHT_LOADER_CHECKSUM_EN.
module conv_weight_loader #(
  parameter  int unsigned NUM_FILTERS = 8,
  parameter  int unsigned KERNEL_TAPS = 9,
  localparam int unsigned DEPTH       = NUM_FILTERS * KERNEL_TAPS,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned FW          = $clog2(NUM_FILTERS),
  localparam int unsigned TW          = $clog2(KERNEL_TAPS + 1),
  localparam int unsigned DW          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  conv_weight_loader_if.slave  s,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [DW-1:0] rd_weight,
  output logic                 loading,
  output logic                 load_done,
  output logic                 load_error,
  output logic [FW-1:0]        wr_filter,
  output logic [TW-1:0]        wr_tap
);

`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, DONE, CHECK, ERROR} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t          state, state_nx;
  logic [FW-1:0]   filter_nx;
  logic [TW-1:0]   tap_nx;
  logic            ready;
  logic            hs;
  logic            wr_en;
  logic            restart;
  logic            last_beat;
  logic            busy_nx;
  logic [AW-1:0]   wr_addr;

  // Weight storage; not reset so trained weights survive rst_n. Simulation starts every entry at +1.
`ifdef SYNTHESIS
  logic [DW-1:0] mem [0:DEPTH-1];
`else
  logic [DW-1:0] mem [0:DEPTH-1] = '{default: DW'(1)};
`endif

`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
  logic [DW-1:0] csum;
`endif

  assign s.s_ready = ready;
  assign hs        = s.s_valid && ready;
  assign last_beat = (wr_filter == FW'(NUM_FILTERS - 1)) && (wr_tap == TW'(KERNEL_TAPS - 1));
  assign wr_addr   = AW'(wr_filter) * AW'(KERNEL_TAPS) + AW'(wr_tap);

  // Next-state, write-index advance and write strobe.
  always_comb begin
    state_nx  = state;
    filter_nx = wr_filter;
    tap_nx    = wr_tap;
    wr_en     = 1'b0;
    restart   = 1'b0;
    busy_nx   = 1'b0;

    case (state)
      LOAD: begin
        if (hs) begin
          wr_en = 1'b1;
          if (wr_tap == TW'(KERNEL_TAPS - 1)) begin
            tap_nx    = '0;
            filter_nx = wr_filter + FW'(1);
          end else begin
            tap_nx = wr_tap + TW'(1);
          end
          if (last_beat) begin
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
            state_nx = CHECK;
`else
            state_nx = DONE;
`endif
          end
        end
      end
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
      CHECK: begin
        if (hs) begin
          state_nx = (s.s_data == csum) ? DONE : ERROR;
        end
      end
`endif
      default: begin
        if (load_start) begin
          restart   = 1'b1;
          state_nx  = LOAD;
          filter_nx = '0;
          tap_nx    = '0;
        end
      end
    endcase

`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
    busy_nx = (state_nx == LOAD) || (state_nx == CHECK);
`else
    busy_nx = (state_nx == LOAD);
`endif
  end

  // State, indices and status flags; flags are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_filter <= '0;
      wr_tap    <= '0;
      ready     <= 1'b0;
      loading   <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_filter <= filter_nx;
      wr_tap    <= tap_nx;
      ready     <= busy_nx;
      loading   <= busy_nx;
      load_done <= (state_nx == DONE);
    end
  end

`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
  // Running mod-256 sum of the accepted weights, compared against the trailing beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum       <= '0;
      load_error <= 1'b0;
    end else begin
      if (restart) begin
        csum <= '0;
      end else if (wr_en) begin
        csum <= csum + DW'(s.s_data);
      end
      load_error <= (state_nx == ERROR);
    end
  end
`else
  assign load_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= DW'(s.s_data);
    end
  end

  // Read-before-write falls out of the non-blocking update above.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_weight <= '0;
    end else if (rd_addr < AW'(DEPTH)) begin
      rd_weight <= mem[rd_addr];
    end else begin
      rd_weight <= '0;
    end
  end

endmodule

// File: tb/tb_conv_weight_loader.sv
// Scoreboard bench for conv_weight_loader: expected read data is queued at request time and
// checked by an independent monitor one cycle later; control/status checked inline.
module tb_conv_weight_loader;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_start;
  logic [6:0]        rd_addr;
  logic signed [7:0] rd_weight;
  logic              loading;
  logic              load_done;
  logic              load_error;
  logic [2:0]        wr_filter;
  logic [3:0]        wr_tap;

  conv_weight_loader_if sif ();

  conv_weight_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .s          (sif),
    .rd_addr    (rd_addr),
    .rd_weight  (rd_weight),
    .loading    (loading),
    .load_done  (load_done),
    .load_error (load_error),
    .wr_filter  (wr_filter),
    .wr_tap     (wr_tap)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_mem [72];
  logic [7:0] rd_q [$];
  logic       rd_en   = 1'b0;
  logic       rd_en_q = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // Read monitor: a request issued before edge N is answered after edge N.
  always @(posedge clk) rd_en_q <= rd_en;

  always @(negedge clk) begin
    if (rd_en_q) begin
      if (rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_scoreboard: read answered with nothing expected");
      end else begin
        check("rd_weight", 8'(rd_weight), rd_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] beat(input int mode, input int i);
    case (mode)
      0:       return 8'(i);
      1:       return 8'(-i);
      2:       return 8'h55;
      3:       return 8'h11;
      default: return 8'h01;
    endcase
  endfunction

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      @(negedge clk);
      rd_addr = 7'(a);
      rd_en   = 1'b1;
      rd_q.push_back((a < 72) ? exp_mem[a] : 8'h00);
    end
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("start_loading", 8'(loading), 8'd1);
    check("start_ready", 8'(sif.s_ready), 8'd1);
    check("start_done_clr", 8'(load_done), 8'd0);
  endtask

  // Streams nbeats weights; optional random gaps, an ignored load_start at beat glitch_at,
  // and (checksum build) a trailing checksum offset by csum_delta.
  task automatic stream(input int mode, input int nbeats, input bit gaps,
                        input int glitch_at, input int csum_delta);
    int         i = 0;
    int         guard = 0;
    bit         hs;
    bit         glitched = 1'b0;
    logic [7:0] sum = 8'h00;
    logic [7:0] b;
    while (i < nbeats && guard < 1000) begin
      check("idx_filter", 8'(wr_filter), 8'(i / 9));
      check("idx_tap", 8'(wr_tap), 8'(i % 9));
      check("done_low_in_load", 8'(load_done), 8'd0);
      b            = beat(mode, i);
      sif.s_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      sif.s_data   = b;
      load_start   = (!glitched && i == glitch_at);
      if (load_start) glitched = 1'b1;
      hs           = sif.s_valid && sif.s_ready;
      @(negedge clk);
      load_start = 1'b0;
      if (hs) begin
        exp_mem[i] = b;
        sum        = sum + b;
        i++;
      end
      guard++;
    end
    sif.s_valid = 1'b0;
    if (i < nbeats) begin
      tests++;
      fails++;
      $display("FAIL stream_timeout: got %0d beats, expected %0d", i, nbeats);
    end
    if (nbeats == 72) begin
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
      check("check_loading", 8'(loading), 8'd1);
      check("check_done_low", 8'(load_done), 8'd0);
      sif.s_valid = 1'b1;
      sif.s_data  = sum + 8'(csum_delta);
      hs          = sif.s_ready;
      @(negedge clk);
      sif.s_valid = 1'b0;
      check("csum_accept", 8'(hs), 8'd1);
`endif
      check("load_done", 8'(load_done), (csum_delta == 0) ? 8'd1 : 8'd0);
      check("load_error", 8'(load_error), (csum_delta == 0) ? 8'd0 : 8'd1);
      check("ready_after", 8'(sif.s_ready), 8'd0);
      check("loading_after", 8'(loading), 8'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 72; k++) exp_mem[k] = 8'h01;
    rst_n       = 1'b0;
    load_start  = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    rd_addr     = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_loading", 8'(loading), 8'd0);
    check("rst_done", 8'(load_done), 8'd0);
    check("rst_error", 8'(load_error), 8'd0);
    check("rst_ready", 8'(sif.s_ready), 8'd0);
    check("rst_filter", 8'(wr_filter), 8'd0);
    check("rst_tap", 8'(wr_tap), 8'd0);
    check("rst_rd_weight", 8'(rd_weight), 8'd0);
    rst_n = 1'b1;
    read_range(5, 5);

    // Full load 0..71, s_valid held high
    start_load();
    stream(0, 72, 1'b0, -1, 0);
    read_range(9, 9);
    read_range(71, 71);

    // Gapped load of -i with an ignored load_start at beat 30
    start_load();
    stream(1, 72, 1'b1, 30, 0);
    read_range(0, 71);
    read_range(72, 72);
    read_range(127, 127);

    // Reset in the middle of a reload over all-0x11 contents
    start_load();
    stream(3, 72, 1'b0, -1, 0);
    start_load();
    stream(2, 40, 1'b1, -1, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_loading", 8'(loading), 8'd0);
    check("midrst_ready", 8'(sif.s_ready), 8'd0);
    check("midrst_done", 8'(load_done), 8'd0);
    check("midrst_filter", 8'(wr_filter), 8'd0);
    check("midrst_tap", 8'(wr_tap), 8'd0);
    rst_n = 1'b1;
    read_range(0, 71);
    check("midrst_done_after", 8'(load_done), 8'd0);

`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
    // All-0x01 weights: checksum 0x48 passes, 0x47 fails
    start_load();
    stream(4, 72, 1'b0, -1, 0);
    start_load();
    stream(4, 72, 1'b1, -1, -1);
    start_load();
    check("err_cleared", 8'(load_error), 8'd0);
    stream(4, 72, 1'b0, -1, 0);
    read_range(0, 3);
`endif

    check("rd_queue_drained", 8'(rd_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_weight_loader.md
# conv_weight_loader

Writable weight store for the 3x3, 1-input-channel, 8-filter convolution stage. It accepts a stream of signed 8-bit weights over a valid/ready handshake and writes them into a 72-entry memory in filter-major order (addr = filter_index*9 + kernel_index). It serves the convolution datapath through a synchronous 1-cycle read port, so trained weights can be loaded at run time instead of being fixed at build time.

## Interface
- NUM_FILTERS, 8, number of filters
- KERNEL_TAPS, 9, taps per filter (3x3 kernel, p00..p22 row-major)
- Derived depth: NUM_FILTERS*KERNEL_TAPS = 72; address width 7
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- load_start  in  1  one-cycle pulse that begins a load sequence
- s_valid  in  1  weight beat valid
- s_data  in  8  signed weight beat
- s_ready  out  1  loader accepts a beat this cycle
- rd_addr  in  7  datapath read address, 0..71
- rd_weight  out  8  signed read data, registered
- loading  out  1  high while in LOAD (or CHECK)
- load_done  out  1  level; all weights written and accepted
- load_error  out  1  level; checksum mismatch (macro only, else 0)
- wr_filter  out  3  filter index of the next beat to be written
- wr_tap  out  4  kernel tap index of the next beat to be written

## Operation
- States: IDLE, LOAD, DONE, plus CHECK and ERROR when the checksum feature is compiled in.
- IDLE: s_ready=0. A load_start pulse moves the FSM to LOAD and clears wr_filter and wr_tap.
- LOAD: s_ready=1. On each cycle with s_valid&&s_ready, write mem[wr_filter*9+wr_tap] <= s_data, then advance the indices:
  - wr_tap increments; at 8 it wraps to 0 and wr_filter increments.
- The beat written at (filter 7, tap 8) is the last. The FSM then goes to DONE, or to CHECK with the macro.
- DONE: s_ready=0 and load_done=1. load_start clears load_done, resets the indices and re-enters LOAD.
- load_start is ignored while in LOAD or CHECK.
- Beats presented while s_ready=0 are not consumed. No overrun is possible.
- Read port:
  - Every cycle, rd_weight <= mem[rd_addr], in any state.
  - rd_addr >= 72 returns 0.
  - A read and a write to the same address in the same cycle return the old data (read-before-write).
- Memory is not cleared by reset. Contents persist across reset and reload.
- In simulation only, all 72 entries initialise to +1.

## Timing
- Reset values: state=IDLE, s_ready=0, loading=0, load_done=0, load_error=0, wr_filter=0, wr_tap=0, rd_weight=0.
- s_ready and loading are decoded from the registered state. They rise the cycle after load_start is sampled.
- load_done rises the cycle after the final beat's handshake.
- Read latency is exactly 1 cycle: address sampled at edge N, data valid after edge N.
- The write takes effect at the handshake edge. A read of that address at the next edge returns the new value.
- A full load with s_valid held high takes 72 handshake cycles, plus 1 cycle to assert load_done.
- Reset asserted mid-load: FSM returns to IDLE and indices clear. Already-written entries keep their new values and the remaining entries keep their old values. load_done stays 0 until a complete reload.

## Configuration
- Macro: CONV_WEIGHT_LOADER_CHECKSUM_EN.
- Defined:
  - After the 72nd weight the FSM enters CHECK with s_ready=1 and accepts one more beat. That beat is the expected 8-bit checksum: the sum of all 72 raw bytes, modulo 256.
  - On a match: go to DONE, load_done=1.
  - On a mismatch: go to ERROR, load_error=1, load_done=0, s_ready=0.
  - load_start from ERROR clears load_error and re-enters LOAD.
  - Memory keeps the written values in both cases.
- Undefined: no CHECK or ERROR states; load_error is tied 0; the loader goes to DONE directly after the 72nd beat.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> all outputs at reset values; read rd_addr=5 -> rd_weight=+1 (simulation init).
- Full load: pulse load_start, stream bytes 0..71 with s_valid held high -> load_done rises 1 cycle after the 72nd handshake; rd_addr=9 -> 9 and rd_addr=71 -> 71, each one cycle later.
- Backpressure and gaps:
  - Toggle s_valid randomly while streaming -(value i) for i=0..71 -> only handshaken beats are written.
  - wr_filter/wr_tap step 0/0 .. 0/8, 1/0 .. 7/8.
  - Readback gives mem[i] = -i.
- Ignored start and out-of-range read: pulse load_start at beat 30 -> indices unaffected and the load completes normally; rd_addr=72 and rd_addr=127 -> rd_weight=0.
- Reset mid-load: assert rst_n=0 after 40 beats of 0x55 over prior all-0x11 contents -> state IDLE; addresses 0..39 read 0x55, 40..71 read 0x11, load_done=0.
- Checksum (macro defined), all weights 0x01:
  - Checksum beat 0x48 -> load_done=1.
  - Checksum beat 0x47 -> load_error=1, load_done=0; a subsequent load_start clears load_error.
